// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and state encoding for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam int          WORD_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// In-order instruction memory bus: req/gnt request handshake, rvalid/rdata responses.
interface instr_prefetch_queue_if #(
    parameter int DATA_SIZE = 32
);

    logic                 req;
    logic [DATA_SIZE-1:0] addr;
    logic                 gnt;
    logic                 rvalid;
    logic [DATA_SIZE-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Single-clock FIFO with synchronous flush; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetcher: credit-limited in-order requests, response FIFO, redirect flush/drain.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [DATA_SIZE-1:0]   redirect_pc,
    input  logic                   stall,
    output logic [DATA_SIZE-1:0]   instr,
    output logic [DATA_SIZE-1:0]   instr_pc,
    output logic [DATA_SIZE-1:0]   pc_plus4,
    output logic                   instr_valid,
    instr_prefetch_queue_if.master mem
);

    localparam int                   CW   = $clog2(DEPTH) + 1;
    localparam logic [DATA_SIZE-1:0] STEP = DATA_SIZE'(WORD_BYTES);

    state_e                 state, state_n;
    logic [DATA_SIZE-1:0]   fetch_pc, fetch_pc_n, rsp_pc, head_instr, head_pc;
    logic [2*DATA_SIZE-1:0] head;
    logic [CW-1:0]          outstanding, occ, discard, discard_n;
    logic [CW:0]            total_after;
    logic                   fire, rsp_keep, pop;
    logic                   dq_empty, dq_full, pq_empty, pq_full;

    // The PC queue holds one entry per live (non-stale) request, so its count is the outstanding count.
    assign mem.req  = !reset && (state == RUN) &&
                      ((CW+1)'(outstanding) + (CW+1)'(occ) < (CW+1)'(DEPTH));
    assign mem.addr = fetch_pc;
    assign fire     = mem.req && mem.gnt;
    assign rsp_keep = mem.rvalid && (discard == '0) && !redirect;
    assign pop      = instr_valid && !stall && !redirect;

    sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(DEPTH)) u_pc_q (
        .clk, .reset,
        .push  (fire && !redirect),
        .pop   (rsp_keep),
        .flush (redirect),
        .wdata (fetch_pc),
        .rdata (rsp_pc),
        .full  (pq_full),
        .empty (pq_empty),
        .count (outstanding)
    );

    sync_fifo #(.WIDTH(2*DATA_SIZE), .DEPTH(DEPTH)) u_data_q (
        .clk, .reset,
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect),
        .wdata ({mem.rdata, rsp_pc}),
        .rdata (head),
        .full  (dq_full),
        .empty (dq_empty),
        .count (occ)
    );

    assign head_instr  = head[2*DATA_SIZE-1:DATA_SIZE];
    assign head_pc     = head[DATA_SIZE-1:0];
    assign instr_valid = !reset && !dq_empty;
    assign instr       = instr_valid ? head_instr : DATA_SIZE'(NOP_INSTR);
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign pc_plus4    = instr_valid ? head_pc + STEP : '0;

    // Requests still in flight once this cycle's grant and response are accounted for.
    assign total_after = (CW+1)'(outstanding) + (CW+1)'(discard)
                       + (CW+1)'(fire) - (CW+1)'(mem.rvalid);

    always_comb begin
        state_n    = state;
        discard_n  = discard;
        fetch_pc_n = fetch_pc;
        if (fire) fetch_pc_n = fetch_pc + STEP;
        if (redirect) begin
            fetch_pc_n = redirect_pc & ~DATA_SIZE'(3);
            discard_n  = total_after[CW-1:0];
            state_n    = (total_after != '0) ? DRAIN : RUN;
        end else begin
            if (mem.rvalid && discard != '0) discard_n = discard - 1'b1;
            case (state)
                RUN:     state_n = RUN;
                DRAIN:   if (discard_n == '0) state_n = RUN;
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            discard  <= discard_n;
        end
    end

    rvalid_has_credit: assert property (@(posedge clk) disable iff (reset)
        mem.rvalid |-> !(pq_empty && discard == '0));

    no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fire && pq_full) && !(rsp_keep && dq_full && !pop));

endmodule
